sibling_sched_ctrl: RTL and testbench
=====================================

# sibling_sched_ctrl

Sequencing controller for a parent node with five sibling child instances (`inst_0`..`inst_4`). On a start request it launches the enabled children one at a time in ascending index order. Each child gets a single-cycle start pulse, and the controller waits for that child's done or a watchdog timeout before moving on. It sits beside the child instances inside the parent node, and a single done/timeout summary goes up to the next level of the tree.

## Interface
Parameters:
- `NUM_CHILD`, 5, number of sequenced children (1..16).
- `TIMEOUT_CYCLES`, 255, WAIT-state cycles allowed per child before timeout (2..65535).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  start request, sampled only in IDLE.
- `abort_i`  in  1  abandons the current sequence.
- `mask_i`  in  NUM_CHILD  children to run, captured on an accepted start.
- `child_start_o`  out  NUM_CHILD  one-hot, one-cycle start pulse to the current child.
- `child_done_i`  in  NUM_CHILD  per-child completion; level or pulse.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when the sequence completes.
- `cur_idx_o`  out  $clog2(NUM_CHILD)  index of the child being served; 0 in IDLE.
- `timeout_flags_o`  out  NUM_CHILD  sticky per-child timeout record for the last sequence.

## Operation
- The controller is a Moore FSM with states IDLE, LAUNCH, WAIT and FINISH.
- State exits:
  - IDLE, on start_i=1 and mask_i≠0: capture mask_q=mask_i, set idx to the lowest set bit, clear timeout_flags, go to LAUNCH.
  - IDLE, on start_i=1 and mask_i=0: go to FINISH, which gives a done_o pulse with no child run.
  - LAUNCH: drive child_start_o[idx]=1, clear the timer, go to WAIT. This is unconditional.
  - WAIT, on child_done_i[idx]=1: clear mask_q[idx]. If mask_q is still nonzero, set idx to the next lowest set bit and go to LAUNCH; otherwise go to FINISH.
  - WAIT, on timer=TIMEOUT_CYCLES-1 without done: set timeout_flags[idx], then leave exactly as for a done.
  - FINISH: done_o=1, go to IDLE.
- Done inputs from children other than idx are ignored.
- If done and timeout occur in the same cycle, done wins and no flag is set.
- start_i while busy is ignored; no queuing.
- abort_i in LAUNCH or WAIT:
  - next state is IDLE;
  - no done_o pulse;
  - timeout_flags are kept;
  - it takes priority over done and timeout.
  - abort_i in IDLE or FINISH has no effect.
- child_start_o, done_o and busy_o are decoded from registered state only. There is no combinational path from any input to any output.
- Timer width is $clog2(TIMEOUT_CYCLES). It increments only in WAIT and saturates; it never wraps.

## Timing
- Reset: state=IDLE, mask_q=0, idx=0, timer=0, timeout_flags=0. All outputs are 0 while rst is high and in the cycle after it is released.
- Reset mid-sequence: IDLE on the next edge with child_start_o=0. No done_o is produced.
- Launch latency: start_i accepted at edge N gives child_start_o high for cycle N+1 only.
- Per-child cost: 1 LAUNCH cycle plus k WAIT cycles, where k ≥ 1 is the first WAIT cycle in which done is seen.
- Full sequence of M enabled children, each done on its first WAIT cycle:
  - done_o is high 2M+1 cycles after the accepting edge;
  - for M=5 that is cycle 11.
- Timeout path: exactly TIMEOUT_CYCLES WAIT cycles are spent on the timed-out child.
- After FINISH, IDLE accepts a new start one cycle after done_o.

## Structure
- Package `sibling_sched_pkg`:
  - `state_e` enum (IDLE, LAUNCH, WAIT, FINISH);
  - `NUM_CHILD_DEFAULT`;
  - function `lowest_set(mask)`, which returns the index of the lowest set bit.
- Sub-module `sched_watchdog`:
  - saturating timer with clear and enable inputs and an `expired` output;
  - parameterised by TIMEOUT_CYCLES.
- Top level: FSM, mask_q/idx registers, output decode.

## Test plan
- Reset, then mask_i=5'b11111 and start_i for one cycle, with each child asserting done one cycle after its start → child_start_o pulses 00001, 00010, 00100, 01000, 10000 at cycles 1,3,5,7,9; done_o at cycle 11; timeout_flags_o=0.
- mask_i=5'b10100 → only children 2 and 4 are started; cur_idx_o goes 2 then 4; done_o at cycle 5.
- TIMEOUT_CYCLES=8, mask=5'b00011, child 0 never completes → child 1 starts 9 cycles after child 0's start; timeout_flags_o=5'b00001 at done_o.
- child_done_i[3] held high while child 1 is being served → ignored; child 1 is still waited on; child 3 is later started normally and completes at once.
- abort_i in WAIT for child 2 → IDLE next cycle; busy_o=0; no done_o; a new start with mask=5'b00001 runs child 0 only.
- Edge cases:
  - start_i with mask_i=0 → done_o one cycle later with no child_start_o activity;
  - rst asserted in LAUNCH → child_start_o=0 on the next cycle and state is IDLE.

Source files
------------

// File: rtl/sibling_sched_pkg.sv
// sibling_sched_pkg: shared state encoding, defaults and mask helper for the sibling scheduler
package sibling_sched_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_e;
  localparam int NUM_CHILD_DEFAULT = 5;
  function automatic logic [3:0] lowest_set(input logic [15:0] mask);
    lowest_set = '0;
    for (int i = 15; i >= 0; i--)
      if (mask[i]) lowest_set = 4'(i);
  endfunction
endpackage

// File: rtl/sched_watchdog.sv
// sched_watchdog: saturating per-child wait timer, expired on the last allowed cycle
module sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
  always_comb
    timer_d = clr ? '0 : (en && timer_q != LAST) ? timer_q + 1'b1 : timer_q;
  always_ff @(posedge clk)
    timer_q <= rst ? '0 : timer_d;
  assign expired = timer_q == LAST;
endmodule

// File: rtl/sibling_sched_ctrl.sv
// sibling_sched_ctrl: launches masked children in ascending order, one at a time, with watchdog
module sibling_sched_ctrl
  import sibling_sched_pkg::*;
#(
  parameter int NUM_CHILD      = NUM_CHILD_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start_i,
  input  logic                                                 abort_i,
  input  logic [NUM_CHILD-1:0]                                 mask_i,
  output logic [NUM_CHILD-1:0]                                 child_start_o,
  input  logic [NUM_CHILD-1:0]                                 child_done_i,
  output logic                                                 busy_o,
  output logic                                                 done_o,
  output logic [(NUM_CHILD > 1 ? $clog2(NUM_CHILD) : 1)-1:0]   cur_idx_o,
  output logic [NUM_CHILD-1:0]                                 timeout_flags_o
);
  localparam int IW = NUM_CHILD > 1 ? $clog2(NUM_CHILD) : 1;
  state_e               state_q, state_d;
  logic [NUM_CHILD-1:0] mask_q, mask_d, flags_q, flags_d, rem;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 hit, expired;
  sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == LAUNCH),
    .en     (state_q == WAIT),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    flags_d = flags_q;
    rem     = mask_q & ~(NUM_CHILD'(1) << idx_q);
    hit     = child_done_i[idx_q];
    case (state_q)
      IDLE:
        if (start_i) begin
          if (|mask_i) begin
            mask_d  = mask_i;
            idx_d   = IW'(lowest_set(16'(mask_i)));
            flags_d = '0;
            state_d = LAUNCH;
          end else begin
            state_d = FINISH;
          end
        end
      LAUNCH: state_d = abort_i ? IDLE : WAIT;
      WAIT:
        if (abort_i) begin
          state_d = IDLE;
        end else if (hit || expired) begin
          mask_d = rem;
          if (!hit) flags_d[idx_q] = 1'b1;
          idx_d   = |rem ? IW'(lowest_set(16'(rem))) : idx_q;
          state_d = |rem ? LAUNCH : FINISH;
        end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      flags_q <= flags_d;
    end
  end
  assign busy_o          = state_q != IDLE;
  assign done_o          = state_q == FINISH;
  assign child_start_o   = (state_q == LAUNCH) ? NUM_CHILD'(1) << idx_q : '0;
  assign cur_idx_o       = busy_o ? idx_q : '0;
  assign timeout_flags_o = flags_q;
endmodule

// File: tb/tb_sibling_sched_ctrl.sv
// tb_sibling_sched_ctrl: directed sequences with a queued expectation scoreboard
module tb_sibling_sched_ctrl;
  typedef struct {
    bit         is_done;
    logic [4:0] vec;
    int         idx;
    int         cyc;
  } evt_t;
  logic       clk = 1'b0;
  logic       rst, start_i, abort_i, busy_o, done_o;
  logic [4:0] mask_i, child_start_o, child_done_i, timeout_flags_o, resp, hold;
  logic [2:0] cur_idx_o;
  int         cyc = 0;
  int         acc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         dly[5];
  int         cnt[5];
  evt_t       exp_q[$];
  assign child_done_i = resp | hold;
  sibling_sched_ctrl #(.NUM_CHILD(5), .TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .mask_i         (mask_i),
    .child_start_o  (child_start_o),
    .child_done_i   (child_done_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .cur_idx_o      (cur_idx_o),
    .timeout_flags_o(timeout_flags_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask
  task automatic push_start(input int i, input int c);
    evt_t e;
    e.is_done = 1'b0;
    e.vec = 5'(1 << i);
    e.idx = i;
    e.cyc = acc + c - 1;
    exp_q.push_back(e);
  endtask
  task automatic push_done(input logic [4:0] flags, input int c);
    evt_t e;
    e.is_done = 1'b1;
    e.vec = flags;
    e.idx = 0;
    e.cyc = acc + c - 1;
    exp_q.push_back(e);
  endtask
  task automatic go(input logic [4:0] m);
    @(negedge clk);
    mask_i  = m;
    start_i = 1'b1;
    acc     = cyc + 1;
  endtask
  task automatic drop();
    @(negedge clk);
    start_i = 1'b0;
    mask_i  = 5'b11111;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    resp = '0;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (child_start_o[i]) begin
          cnt[i]  = dly[i];
          resp[i] = 1'b0;
        end else if (cnt[i] != 0) begin
          cnt[i]--;
          resp[i] = cnt[i] == 0;
        end else begin
          resp[i] = 1'b0;
        end
      end
    end
  end
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (child_start_o != 0 || done_o) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: start=%b done=%b cyc=%0d, required no activity",
                   child_start_o, done_o, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("evt_kind", int'(done_o), int'(e.is_done));
          chk(e.is_done ? "done_cyc" : "start_cyc", cyc, e.cyc);
          if (e.is_done) begin
            chk("done_flags", timeout_flags_o, e.vec);
          end else begin
            chk("start_vec", child_start_o, e.vec);
            chk("start_idx", cur_idx_o, e.idx);
          end
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck required finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; mask_i = '0; hold = '0;
    for (int i = 0; i < 5; i++) dly[i] = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_start", child_start_o, 0);
    chk("rst_flags", timeout_flags_o, 0);
    chk("rst_idx", cur_idx_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_start", child_start_o, 0);
    go(5'b11111);
    for (int i = 0; i < 5; i++) push_start(i, 1 + 2 * i);
    push_done(5'b00000, 11);
    drop();
    wait_idle();
    go(5'b10100);
    push_start(2, 1);
    push_start(4, 3);
    push_done(5'b00000, 5);
    drop();
    wait_idle();
    dly[0] = 0;
    go(5'b00011);
    push_start(0, 1);
    push_start(1, 10);
    push_done(5'b00001, 12);
    drop();
    wait_idle();
    dly[0] = 8;
    go(5'b00001);
    push_start(0, 1);
    push_done(5'b00000, 10);
    drop();
    wait_idle();
    dly[0] = 1;
    hold = 5'b01000; dly[1] = 3; dly[3] = 0;
    go(5'b01010);
    push_start(1, 1);
    push_start(3, 5);
    push_done(5'b00000, 7);
    drop();
    wait_idle();
    hold = '0; dly[1] = 1; dly[3] = 1;
    dly[2] = 0;
    go(5'b00111);
    push_start(0, 1);
    push_start(1, 3);
    push_start(2, 5);
    drop();
    while (cyc < acc + 5) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_idx", cur_idx_o, 0);
    chk("abort_pending", exp_q.size(), 0);
    chk("abort_flags", timeout_flags_o, 0);
    dly[2] = 1;
    go(5'b00001);
    push_start(0, 1);
    push_done(5'b00000, 3);
    drop();
    wait_idle();
    go(5'b00000);
    push_done(5'b00000, 1);
    drop();
    wait_idle();
    go(5'b00001);
    push_start(0, 1);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_launch_start", child_start_o, 0);
    chk("rst_launch_busy", busy_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_busy", busy_o, 0);
    chk("rst_rel_done", done_o, 0);
    repeat (4) @(negedge clk);
    chk("final_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
